// File: rtl/pc_npc_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours:
// fetch FSM encodings, the default squash word and the sequential PC step.
package pc_npc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_RUN     = 2'd1,
      S_SQUASH  = 2'd2,
      S_ILLEGAL = 2'd3
   } fetch_state_t;

   // SPARC "sethi 0, %g0" is the canonical nop.
   localparam logic [31:0] NOP_INSTR_SPARC = 32'h0100_0000;
   localparam logic [31:0] PC_INCR         = 32'd4;

endpackage

// File: rtl/pc_npc_fetch_unit_if_id_pipe_reg.sv
// IF/ID pipeline register: loads the fetched word and its PC when enabled,
// optionally replacing the word with a nop for an annulled delay slot.
module if_id_pipe_reg
   import pc_npc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_SPARC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        inject_nop,
   input  logic        mark_valid,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] fetch_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        valid
);

   // Load-enabled capture; a squashed slot carries the nop and is marked invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr <= NOP_INSTR;
         pc    <= 32'd0;
         valid <= 1'b0;
      end else if (load) begin
         instr <= inject_nop ? NOP_INSTR : fetch_instr;
         pc    <= fetch_pc;
         valid <= mark_valid;
      end
   end

endmodule

// File: rtl/pc_npc_fetch_unit.sv
// SPARC-style PC/nPC fetch unit with delayed-branch resolution and
// annul-driven delay-slot squash.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_INIT   | first fetch after reset; IF/ID loads but stays invalid
//   S_RUN    | normal fetch; CTIs in ID resolve here
//   S_SQUASH | delay slot was annulled; next fetch is the normal one
//   S_ILLEGAL| unreachable encoding; recovers to S_INIT
module pc_npc_fetch_unit
   import pc_npc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_SPARC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_LE,
   input  logic        nPC_LE,
   input  logic        IF_ID_LE,
   input  logic [31:0] IF_instr,
   input  logic        ID_cti,
   input  logic        ID_taken,
   input  logic [31:0] ID_target,
   input  logic        ID_annul,
   input  logic        ID_ba,
   output logic [31:0] PC,
   output logic [31:0] nPC,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_PC,
   output logic        IF_ID_valid,
   output logic [1:0]  fetch_state
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, npc_q;
   logic         adv, res, sq;
   logic         ifid_load, inject_nop, mark_valid, pc_load, take_target;

   // A stall from any of the three enables freezes the whole front end.
   assign adv = PC_LE & nPC_LE & IF_ID_LE;
   assign res = adv & ID_cti & (state_q == S_RUN);
   assign sq  = res & ID_annul & (ID_ba | ~ID_taken);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   // Next-state and datapath controls.
   always_comb begin
      state_d     = state_q;
      ifid_load   = 1'b0;
      inject_nop  = 1'b0;
      mark_valid  = 1'b0;
      pc_load     = 1'b0;
      take_target = 1'b0;
      case (state_q)
         S_INIT: begin
            if (adv) begin
               ifid_load = 1'b1;
               pc_load   = 1'b1;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (adv) begin
               ifid_load   = 1'b1;
               pc_load     = 1'b1;
               take_target = res & ID_taken;
               if (sq) begin
                  inject_nop = 1'b1;
                  state_d    = S_SQUASH;
               end else begin
                  mark_valid = 1'b1;
               end
            end
         end
         S_SQUASH: begin
            if (adv) begin
               ifid_load  = 1'b1;
               pc_load    = 1'b1;
               mark_valid = 1'b1;
               state_d    = S_RUN;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // PC/nPC pair: PC follows nPC; nPC either steps or takes the branch target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         npc_q <= RESET_PC + PC_INCR;
      end else if (pc_load) begin
         pc_q  <= npc_q;
         npc_q <= take_target ? ID_target : (npc_q + PC_INCR);
      end
   end

   if_id_pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk         (clk),
      .reset       (reset),
      .load        (ifid_load),
      .inject_nop  (inject_nop),
      .mark_valid  (mark_valid),
      .fetch_instr (IF_instr),
      .fetch_pc    (pc_q),
      .instr       (IF_ID_instr),
      .pc          (IF_ID_PC),
      .valid       (IF_ID_valid)
   );

   assign PC          = pc_q;
   assign nPC         = npc_q;
   assign fetch_state = state_q;

endmodule

// File: tb/tb_pc_npc_fetch_unit.sv
// Bench for pc_npc_fetch_unit: directed delayed-branch scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_npc_fetch_unit;

   localparam logic [31:0] NOP = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        PC_LE, nPC_LE, IF_ID_LE;
   logic [31:0] IF_instr;
   logic        ID_cti, ID_taken, ID_annul, ID_ba;
   logic [31:0] ID_target;
   logic [31:0] PC, nPC, IF_ID_instr, IF_ID_PC;
   logic        IF_ID_valid;
   logic [1:0]  fetch_state;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   // behavioural model: mode 0=init, 1=run, 2=squash
   logic [31:0] m_pc, m_npc, m_instr, m_ifpc;
   logic        m_valid;
   int          m_mode;

   pc_npc_fetch_unit dut (
      .clk(clk), .reset(reset),
      .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE),
      .IF_instr(IF_instr),
      .ID_cti(ID_cti), .ID_taken(ID_taken), .ID_target(ID_target),
      .ID_annul(ID_annul), .ID_ba(ID_ba),
      .PC(PC), .nPC(nPC), .IF_ID_instr(IF_ID_instr), .IF_ID_PC(IF_ID_PC),
      .IF_ID_valid(IF_ID_valid), .fetch_state(fetch_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_pc = 32'd0; m_npc = 32'd4; m_instr = NOP; m_ifpc = 32'd0;
      m_valid = 1'b0; m_mode = 0;
   endtask

   // Apply one clock edge's worth of the fetch rules to the model.
   task automatic model_step();
      bit adv, res, sq;
      adv = PC_LE && nPC_LE && IF_ID_LE;
      if (!adv) return;
      res = ID_cti && (m_mode == 1);
      sq  = res && ID_annul && (ID_ba || !ID_taken);
      m_ifpc = m_pc;
      if (sq) begin
         m_instr = NOP; m_valid = 1'b0; m_mode = 2;
      end else begin
         m_instr = IF_instr;
         m_valid = (m_mode != 0);
         m_mode  = 1;
      end
      m_pc  = m_npc;
      m_npc = (res && ID_taken) ? ID_target : m_npc + 32'd4;
   endtask

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("pc", PC, m_pc);
         check("npc", nPC, m_npc);
         check("ifid_instr", IF_ID_instr, m_instr);
         check("ifid_pc", IF_ID_PC, m_ifpc);
         check("ifid_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
         check("state", {30'd0, fetch_state}, m_mode);
      end
   end

   task automatic cyc(input bit pl, input bit nl, input bit il, input bit cti,
                      input bit tk, input logic [31:0] tgt, input bit an, input bit ba);
      PC_LE = pl; nPC_LE = nl; IF_ID_LE = il;
      ID_cti = cti; ID_taken = tk; ID_target = tgt; ID_annul = an; ID_ba = ba;
      IF_instr = mem_word(m_pc);
      model_step();
      @(posedge clk);
      @(negedge clk);
      #2;
   endtask

   task automatic run1(); cyc(1, 1, 1, 0, 0, 32'd0, 0, 0); endtask

   // Async reset between edges, checked before any clock can act.
   task automatic async_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_pc", PC, 32'd0);
      check("rst_npc", nPC, 32'd4);
      check("rst_instr", IF_ID_instr, NOP);
      check("rst_ifpc", IF_ID_PC, 32'd0);
      check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
      check("rst_state", {30'd0, fetch_state}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      PC_LE = 1; nPC_LE = 1; IF_ID_LE = 1; IF_instr = 0;
      ID_cti = 0; ID_taken = 0; ID_target = 0; ID_annul = 0; ID_ba = 0;
      model_reset();
      @(negedge clk);
      #2;
      cmp_en = 1'b1;
      async_reset();

      // reset release: stall in INIT holds, then 0,4,8,C
      cyc(1, 0, 1, 1, 1, 32'h80, 1, 1);
      check("init_stall_state", {30'd0, fetch_state}, 32'd0);
      check("init_stall_pc", PC, 32'd0);
      run1();
      check("r1_pc", PC, 32'h4);
      check("r1_valid", {31'd0, IF_ID_valid}, 32'd0);
      check("r1_state", {30'd0, fetch_state}, 32'd1);
      run1();
      check("r2_pc", PC, 32'h8);
      check("r2_valid", {31'd0, IF_ID_valid}, 32'd1);
      run1();
      check("r3_pc", PC, 32'hC);

      for (int i = 0; i < 64 && m_pc != 32'h40; i++) run1();
      check("reach_40", PC, 32'h40);

      // taken, a=0: delay slot executes, then target
      cyc(1, 1, 1, 1, 1, 32'h100, 0, 0);
      check("br_pc", PC, 32'h44);
      check("br_npc", nPC, 32'h100);
      check("br_valid", {31'd0, IF_ID_valid}, 32'd1);
      run1();
      check("br_tgt", PC, 32'h100);

      // untaken, a=1: delay slot squashed
      cyc(1, 1, 1, 1, 0, 32'h900, 1, 0);
      check("sq_instr", IF_ID_instr, NOP);
      check("sq_valid", {31'd0, IF_ID_valid}, 32'd0);
      check("sq_state", {30'd0, fetch_state}, 32'd2);
      check("sq_npc", nPC, 32'h108);
      run1();
      check("sq_back", {30'd0, fetch_state}, 32'd1);
      check("sq_back_valid", {31'd0, IF_ID_valid}, 32'd1);

      // taken, a=1, not ba: no squash
      cyc(1, 1, 1, 1, 1, 32'h200, 1, 0);
      check("ta_state", {30'd0, fetch_state}, 32'd1);
      check("ta_valid", {31'd0, IF_ID_valid}, 32'd1);
      run1();
      check("ta_pc", PC, 32'h200);

      // ba,a: squash and still go to target
      cyc(1, 1, 1, 1, 1, 32'h300, 1, 1);
      check("ba_state", {30'd0, fetch_state}, 32'd2);
      check("ba_npc", nPC, 32'h300);
      run1();
      check("ba_pc", PC, 32'h300);

      // stall with a pending CTI
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 1, 1, 32'h400, 0, 0);
         check("stall_pc", PC, 32'h300);
         check("stall_npc", nPC, 32'h304);
      end
      cyc(1, 1, 1, 1, 1, 32'h400, 0, 0);
      check("stall_res", nPC, 32'h400);

      // nPC wrap
      cyc(1, 1, 1, 1, 1, 32'hFFFF_FFF8, 0, 0);
      run1();
      run1();
      check("wrap_pc", PC, 32'hFFFF_FFFC);
      check("wrap_npc", nPC, 32'h0);

      // reset while in S_SQUASH
      cyc(1, 1, 1, 1, 0, 32'h0, 1, 0);
      check("pre_rst_state", {30'd0, fetch_state}, 32'd2);
      async_reset();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 1) == 1, {$urandom(), 2'b00} & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
